// File: rtl/sine_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : sine_freq_meter
// Brief    : Recovers the DDS frequency increment of a sampled sine by timing
//            rising hysteresis crossings and dividing 2^ACC_BITS by the period.
// Revision : 1.0 - initial release
// ============================================================================
module sine_freq_meter #(
    parameter int ACC_BITS = 14,
    parameter int CNT_BITS = 15,
    parameter int HYST     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [9:0]          subsample_phase,
    input  logic [6:0]          sample_in,
    output logic [ACC_BITS-3:0] freq_est,
    output logic                est_valid,
    output logic                locked
);

    localparam int QW = ACC_BITS + 1;
    localparam int SW = $clog2(ACC_BITS + 2);
    localparam logic [6:0]          HI_TH    = 7'(64 + HYST);
    localparam logic [6:0]          LO_TH    = 7'(64 - HYST);
    localparam logic [CNT_BITS-1:0] CNT_LAST = {{(CNT_BITS-1){1'b1}}, 1'b0};
    localparam logic [SW-1:0]       STEP_END = SW'(ACC_BITS + 1);

    typedef enum logic [1:0] {UNARMED, MEASURE, DIVIDE} state_t;

    state_t              state, state_nx;
    logic                cmp_hi;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] period;
    logic [CNT_BITS-1:0] rem;
    logic [QW-1:0]       quo;
    logic [SW-1:0]       step;

    logic                sample_ev;
    logic                rise;
    logic                timeout;
    logic                div_done;
    logic [CNT_BITS:0]   rem_sh;
    logic [CNT_BITS-1:0] sub;
    logic                qbit;
    logic [CNT_BITS-1:0] rem_nx;
    logic [ACC_BITS-3:0] q_sat;

    assign sample_ev = (subsample_phase == 10'd9);
    assign rise      = sample_ev && !cmp_hi && (sample_in >= HI_TH);
    assign timeout   = (state == MEASURE) && sample_ev && !rise && (cnt == CNT_LAST);
    assign div_done  = (state == DIVIDE) && (step == STEP_END);

    // Dividend is 2^ACC_BITS: its only set bit enters on the first step.
    // A remainder below the divisor lets the low bits of the subtraction stand alone.
    assign rem_sh = {rem, (step == '0)};
    assign sub    = rem_sh[CNT_BITS-1:0] - period;
    assign qbit   = (rem_sh >= {1'b0, period});
    assign rem_nx = qbit ? sub : rem_sh[CNT_BITS-1:0];
    assign q_sat  = (|quo[QW-1:ACC_BITS-2]) ? '1 : quo[ACC_BITS-3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= UNARMED;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            UNARMED: if (rise) state_nx = MEASURE;
            MEASURE: begin
                if (rise)         state_nx = DIVIDE;
                else if (timeout) state_nx = UNARMED;
            end
            DIVIDE:  if (div_done) state_nx = MEASURE;
            default: state_nx = UNARMED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_hi    <= 1'b1;
            cnt       <= '0;
            period    <= '0;
            rem       <= '0;
            quo       <= '0;
            step      <= '0;
            freq_est  <= '0;
            est_valid <= 1'b0;
            locked    <= 1'b0;
        end else begin
            est_valid <= 1'b0;
            if (sample_ev) begin
                if (sample_in >= HI_TH)      cmp_hi <= 1'b1;
                else if (sample_in <= LO_TH) cmp_hi <= 1'b0;
            end
            case (state)
                UNARMED: begin
                    if (rise) cnt <= CNT_BITS'(1);
                end
                MEASURE: begin
                    if (rise) begin
                        period <= cnt;
                        cnt    <= CNT_BITS'(1);
                        rem    <= '0;
                        quo    <= '0;
                        step   <= '0;
                    end else if (timeout) begin
                        cnt    <= '0;
                        locked <= 1'b0;
                    end else if (sample_ev) begin
                        cnt    <= cnt + 1'b1;
                    end
                end
                DIVIDE: begin
                    // A crossing here is treated as an ordinary sample event.
                    if (sample_ev) cnt <= cnt + 1'b1;
                    if (div_done) begin
                        freq_est  <= q_sat;
                        est_valid <= 1'b1;
                        locked    <= 1'b1;
                    end else begin
                        rem  <= rem_nx;
                        quo  <= {quo[QW-2:0], qbit};
                        step <= step + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sine_freq_meter.sv
`default_nettype none
// Scoreboard bench: a frame-level crossing model queues expected estimates and
// their arrival cycle; a negedge monitor pops and compares on every est_valid.
module tb_sine_freq_meter;

    localparam int ACC   = 14;
    localparam int CNTB  = 8;
    localparam int HY    = 4;
    localparam int FRAME = 32;   // shortened frame; the meter only keys on phase 9

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [9:0]      phase = '0;
    logic [6:0]      sample = 7'd64;
    logic [ACC-3:0]  freq_est;
    logic            est_valid;
    logic            locked;

    sine_freq_meter #(.ACC_BITS(ACC), .CNT_BITS(CNTB), .HYST(HY)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .subsample_phase (phase),
        .sample_in       (sample),
        .freq_est        (freq_est),
        .est_valid       (est_valid),
        .locked          (locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int val; int at; } exp_t;
    exp_t sbq[$];

    int total = 0;
    int bad   = 0;

    bit m_hi, m_armed, m_locked, m_rose;
    int m_ref, m_freq;
    int frame_no = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int expect_q(input int p);
        int q;
        q = (1 << ACC) / p;
        return (q > (1 << (ACC - 2)) - 1) ? (1 << (ACC - 2)) - 1 : q;
    endfunction

    task automatic model_reset();
        m_hi = 1'b1; m_armed = 1'b0; m_locked = 1'b0; m_freq = 0;
        sbq.delete();
    endtask

    // One sample per frame; period in frames is the gap between rising crossings.
    task automatic model_sample(input int s);
        int v;
        m_rose = !m_hi && (s >= 64 + HY);
        if (s >= 64 + HY)      m_hi = 1'b1;
        else if (s <= 64 - HY) m_hi = 1'b0;
        if (m_rose) begin
            if (m_armed) begin
                v = expect_q(frame_no - m_ref);
                sbq.push_back('{val: v, at: cyc + 1 + ACC + 2});
                m_locked = 1'b1;
                m_freq   = v;
            end
            m_armed = 1'b1;
            m_ref   = frame_no;
        end else if (m_armed && (frame_no - m_ref + 1 >= (1 << CNTB) - 1)) begin
            m_armed  = 1'b0;
            m_locked = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && est_valid) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_est: got pulse freq_est=%0d at cycle %0d, required none", freq_est, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("est_value", int'(freq_est), e.val);
                check("est_time", cyc, e.at);
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_freq_est"}, int'(freq_est), 0);
        check({tag, "_est_valid"}, int'(est_valid), 0);
        check({tag, "_locked"}, int'(locked), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        phase = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
    endtask

    task automatic run_frame(input int s, input bit rst_mid);
        for (int ph = 0; ph < FRAME; ph++) begin
            @(negedge clk);
            phase = 10'(ph);
            if (ph == 8) sample = 7'(s);
            if (ph == 9) model_sample(s);
            if (rst_mid && m_rose && ph == 14) begin
                rst_n = 1'b0;
                model_reset();
            end
            if (rst_mid && !rst_n && ph == 15) check_zero("mid_div_reset");
            if (ph == 17) rst_n = 1'b1;
            if (ph == FRAME - 1) begin
                check("locked", int'(locked), int'(m_locked));
                check("freq_est_hold", int'(freq_est), m_freq);
            end
        end
        frame_no++;
    endtask

    task automatic square(input int half, input int periods, input int lo, input int hi);
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < half; i++) run_frame(lo, 1'b0);
            for (int i = 0; i < half; i++) run_frame(hi, 1'b0);
        end
    endtask

    initial begin
        int acc;
        int s;
        #2 rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("por");
        rst_n = 1'b1;

        // DDS sine at increment 256: period 64 frames
        acc = 0;
        for (int f = 0; f < 4 * 64 + 4; f++) begin
            s = $rtoi(64.0 + 63.0 * $sin(2.0 * 3.14159265358979 * acc / 16384.0) + 0.5);
            run_frame(s, 1'b0);
            acc = (acc + 256) % 16384;
        end
        check("sine_locked", int'(locked), 1);
        check("sine_freq", int'(freq_est), 256);

        square(4, 6, 20, 108);
        check("p8_freq", int'(freq_est), 2048);
        square(1, 12, 20, 108);
        check("p2_saturated", int'(freq_est), 4095);

        // No crossings inside or at the hysteresis band
        do_reset();
        for (int f = 0; f < 20; f++) run_frame(64, 1'b0);
        for (int f = 0; f < 20; f++) run_frame((f % 2) ? 66 : 62, 1'b0);
        check("band_locked", int'(locked), 0);

        // Timeout after losing crossings, estimate retained, then relock
        do_reset();
        square(8, 4, 20, 108);
        check("to_pre_locked", int'(locked), 1);
        for (int f = 0; f < 270; f++) run_frame(100, 1'b0);
        check("to_locked", int'(locked), 0);
        check("to_freq_kept", int'(freq_est), 1024);
        square(8, 3, 20, 108);
        check("to_relocked", int'(locked), 1);

        // Reset in the middle of a division
        square(4, 2, 20, 108);
        for (int f = 0; f < 4; f++) run_frame(20, 1'b0);
        run_frame(108, 1'b1);
        check_zero("after_mid_reset");
        square(4, 3, 20, 108);
        check("mid_relock_freq", int'(freq_est), 2048);

        // Randomized square waves with random levels, then raw random samples
        for (int b = 0; b < 10; b++) begin
            square($urandom_range(1, 8), $urandom_range(2, 4),
                   $urandom_range(0, 60), $urandom_range(68, 127));
        end
        for (int f = 0; f < 150; f++) run_frame($urandom_range(0, 127), 1'b0);

        for (int f = 0; f < 2; f++) run_frame(64, 1'b0);
        check("scoreboard_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
